// File: rtl/pc_sequencer.sv
// Registered fetch program counter with conditional PC-relative branch,
// branch-with-link and conditional return through a circular return-address stack.
module pc_sequencer #(
  parameter int unsigned       ADDR_W       = 32,
  parameter int unsigned       OFFSET_W     = 24,
  parameter int unsigned       OFFSET_SHIFT = 2,
  parameter int unsigned       PC_INCR      = 4,
  parameter logic [ADDR_W-1:0] RESET_PC     = '0,
  parameter int unsigned       RAS_DEPTH    = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                stall,
  input  logic                inst_valid,
  input  logic                branch_inst,
  input  logic                link,
  input  logic                ret,
  input  logic                cond_execute,
  input  logic [OFFSET_W-1:0] offset,
  output logic [ADDR_W-1:0]   pc,
  output logic                taken,
  output logic [ADDR_W-1:0]   link_addr,
  output logic                ras_empty,
  output logic                ras_full,
  output logic                ras_underflow
);

  localparam int unsigned       PTR_W   = $clog2(RAS_DEPTH);
  localparam int unsigned       CNT_W   = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] ras [RAS_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, wr_ptr_nxt, top_ptr;
  logic [CNT_W-1:0]  count, count_nxt;
  logic [ADDR_W-1:0] pc_nxt, link_addr_nxt, seq, target, offset_ext;
  logic              taken_nxt, underflow_nxt, push, advance;

  always_comb begin
    advance       = !stall && inst_valid;
    offset_ext    = ADDR_W'(signed'(offset)) << OFFSET_SHIFT;
    seq           = pc + ADDR_W'(PC_INCR);
    target        = seq + offset_ext;
    top_ptr       = wr_ptr - PTR_W'(1);
    pc_nxt        = pc;
    link_addr_nxt = link_addr;
    wr_ptr_nxt    = wr_ptr;
    count_nxt     = count;
    taken_nxt     = 1'b0;
    underflow_nxt = 1'b0;
    push          = 1'b0;
    if (advance) begin
      pc_nxt = seq;
      if (branch_inst && cond_execute) begin
        pc_nxt    = target;
        taken_nxt = 1'b1;
        if (link) begin
          // Full stack: pointer wraps onto the oldest entry, count saturates.
          push          = 1'b1;
          link_addr_nxt = seq;
          wr_ptr_nxt    = wr_ptr + PTR_W'(1);
          if (count != CNT_MAX) count_nxt = count + CNT_W'(1);
        end
      end else if (ret && cond_execute) begin
        if (count != '0) begin
          pc_nxt     = ras[top_ptr];
          wr_ptr_nxt = top_ptr;
          count_nxt  = count - CNT_W'(1);
          taken_nxt  = 1'b1;
        end else begin
          underflow_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc            <= RESET_PC;
      taken         <= 1'b0;
      link_addr     <= '0;
      ras_underflow <= 1'b0;
      wr_ptr        <= '0;
      count         <= '0;
    end else begin
      pc            <= pc_nxt;
      taken         <= taken_nxt;
      link_addr     <= link_addr_nxt;
      ras_underflow <= underflow_nxt;
      wr_ptr        <= wr_ptr_nxt;
      count         <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && push) ras[wr_ptr] <= seq;
  end

  assign ras_empty = (count == '0);
  assign ras_full  = (count == CNT_MAX);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer: the driver queues hand-computed
// post-edge expectations, a monitor pops and compares one entry per clock.
module tb_pc_sequencer;

  logic        clk, reset_n, stall, inst_valid, branch_inst, link, ret, cond_execute;
  logic [23:0] offset;
  logic [31:0] pc, link_addr;
  logic        taken, ras_empty, ras_full, ras_underflow;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] la;
    logic        empty;
    logic        full;
    logic        uf;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  pc_sequencer #(
    .ADDR_W(32), .OFFSET_W(24), .OFFSET_SHIFT(2), .PC_INCR(4),
    .RESET_PC(32'h0), .RAS_DEPTH(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .inst_valid(inst_valid),
    .branch_inst(branch_inst), .link(link), .ret(ret), .cond_execute(cond_execute),
    .offset(offset), .pc(pc), .taken(taken), .link_addr(link_addr),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_underflow(ras_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int unsigned idx,
                     input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%h expected=%h", name, idx, act, expv);
    end
  endtask

  // Monitor: one expectation per rising edge, sampled just after it.
  initial begin
    int unsigned idx = 0;
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pc",            idx, pc,                   e.pc);
        chk("taken",         idx, {31'b0, taken},        {31'b0, e.taken});
        chk("link_addr",     idx, link_addr,            e.la);
        chk("ras_empty",     idx, {31'b0, ras_empty},     {31'b0, e.empty});
        chk("ras_full",      idx, {31'b0, ras_full},      {31'b0, e.full});
        chk("ras_underflow", idx, {31'b0, ras_underflow}, {31'b0, e.uf});
        idx++;
      end
    end
  end

  task automatic drv(input logic r, input logic s, input logic v, input logic b,
                     input logic l, input logic t, input logic c, input logic [23:0] off,
                     input logic [31:0] e_pc, input logic e_tk, input logic [31:0] e_la,
                     input logic e_em, input logic e_fu, input logic e_uf);
    exp_t e;
    @(negedge clk);
    reset_n = r; stall = s; inst_valid = v; branch_inst = b;
    link = l; ret = t; cond_execute = c; offset = off;
    e.pc = e_pc; e.taken = e_tk; e.la = e_la; e.empty = e_em; e.full = e_fu; e.uf = e_uf;
    exp_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; stall = 1'b0; inst_valid = 1'b0; branch_inst = 1'b0;
    link = 1'b0; ret = 1'b0; cond_execute = 1'b0; offset = '0;

    //   r s v b l t c offset        pc            tk la         em fu uf
    drv(0,0,0,0,0,0,0,24'h0,      32'h0,        0, 32'h0,     1, 0, 0);
    drv(1,0,1,0,0,0,0,24'h0,      32'h4,        0, 32'h0,     1, 0, 0);
    drv(1,0,1,0,0,0,0,24'h0,      32'h8,        0, 32'h0,     1, 0, 0);
    drv(1,0,1,0,0,0,0,24'h0,      32'hC,        0, 32'h0,     1, 0, 0);
    // PC-relative branches: forward, backward, failed condition
    drv(1,0,1,1,0,0,1,24'h000002, 32'd24,       1, 32'h0,     1, 0, 0);
    drv(1,0,1,1,0,0,1,24'hFFFFFE, 32'd20,       1, 32'h0,     1, 0, 0);
    drv(1,0,1,1,0,0,0,24'hFFFFFE, 32'd24,       0, 32'h0,     1, 0, 0);
    drv(1,0,1,1,0,0,1,24'h000039, 32'h100,      1, 32'h0,     1, 0, 0);
    // BL then return; failed-condition BL and ret are ignored
    drv(1,0,1,1,1,0,1,24'h000010, 32'h144,      1, 32'h104,   0, 0, 0);
    drv(1,0,1,0,0,1,1,24'h0,      32'h104,      1, 32'h104,   1, 0, 0);
    drv(1,0,1,1,1,0,0,24'h000010, 32'h108,      0, 32'h104,   1, 0, 0);
    drv(1,0,1,0,0,1,0,24'h0,      32'h10C,      0, 32'h104,   1, 0, 0);
    // five BLs A1..A5 (A5 overwrites A1)
    drv(1,0,1,1,1,0,1,24'h0,      32'h110,      1, 32'h110,   0, 0, 0);
    drv(1,0,1,1,1,0,1,24'h0,      32'h114,      1, 32'h114,   0, 0, 0);
    drv(1,0,1,1,1,0,1,24'h0,      32'h118,      1, 32'h118,   0, 0, 0);
    drv(1,0,1,1,1,0,1,24'h0,      32'h11C,      1, 32'h11C,   0, 1, 0);
    drv(1,0,1,1,1,0,1,24'h0,      32'h120,      1, 32'h120,   0, 1, 0);
    // five returns: A5, A4, A3, A2, then underflow
    drv(1,0,1,0,0,1,1,24'h0,      32'h120,      1, 32'h120,   0, 0, 0);
    drv(1,0,1,0,0,1,1,24'h0,      32'h11C,      1, 32'h120,   0, 0, 0);
    drv(1,0,1,0,0,1,1,24'h0,      32'h118,      1, 32'h120,   0, 0, 0);
    drv(1,0,1,0,0,1,1,24'h0,      32'h114,      1, 32'h120,   1, 0, 0);
    drv(1,0,1,0,0,1,1,24'h0,      32'h118,      0, 32'h120,   1, 0, 1);
    drv(1,0,1,0,0,0,0,24'h0,      32'h11C,      0, 32'h120,   1, 0, 0);
    // stall holding a taken BL for three cycles, then release
    drv(1,0,1,1,1,0,1,24'h0,      32'h120,      1, 32'h120,   0, 0, 0);
    drv(1,1,1,1,1,0,1,24'h000004, 32'h120,      0, 32'h120,   0, 0, 0);
    drv(1,1,1,1,1,0,1,24'h000004, 32'h120,      0, 32'h120,   0, 0, 0);
    drv(1,1,1,1,1,0,1,24'h000004, 32'h120,      0, 32'h120,   0, 0, 0);
    drv(1,0,1,1,1,0,1,24'h000004, 32'h134,      1, 32'h124,   0, 0, 0);
    drv(1,0,0,0,0,0,0,24'h0,      32'h134,      0, 32'h124,   0, 0, 0);
    // reset beats stall and a pending BL with two entries stacked
    drv(0,1,1,1,1,0,1,24'h000004, 32'h0,        0, 32'h0,     1, 0, 0);
    drv(1,0,1,0,0,1,1,24'h0,      32'h4,        0, 32'h0,     1, 0, 1);
    // wrap-around at the top of the address space
    drv(1,0,1,1,0,0,1,24'hFFFFFD, 32'hFFFFFFFC, 1, 32'h0,     1, 0, 0);
    drv(1,0,1,0,0,0,0,24'h0,      32'h0,        0, 32'h0,     1, 0, 0);
    drv(1,0,1,0,0,0,0,24'h0,      32'h4,        0, 32'h0,     1, 0, 0);
    // branch outranks a simultaneous return
    drv(1,0,1,1,1,0,1,24'h0,      32'h8,        1, 32'h8,     0, 0, 0);
    drv(1,0,1,1,0,1,1,24'h000001, 32'h10,       1, 32'h8,     0, 0, 0);
    drv(1,0,1,0,0,1,1,24'h0,      32'h8,        1, 32'h8,     1, 0, 0);

    @(negedge clk);
    inst_valid = 1'b0; branch_inst = 1'b0; link = 1'b0; ret = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
